uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 116 +++++++++++
 tb/tb_uart_rx.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver feeding a show-ahead byte FIFO
module uart_rx #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       frame_err,
  output logic       overrun
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam int TW    = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q, state_d;
  logic          rx_meta_q, rx_s_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic          frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic          push, bad, pop, wr;
  assign empty     = count_q == '0;
  assign full      = count_q == CW'(DEPTH);
  assign dout      = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  // Framing FSM: sample mid-bit, shift LSB first, judge the stop bit
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    push    = 1'b0;
    bad     = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        state_d = rx_s_q ? IDLE : START;
      end
      START: if (timer_q == T_HALF) begin
        timer_d = '0;
        idx_d   = '0;
        state_d = rx_s_q ? IDLE : DATA;
      end
      DATA: if (timer_q == T_FULL) begin
        timer_d = '0;
        shift_d = {rx_s_q, shift_q[7:1]};
        idx_d   = idx_q + 3'd1;
        state_d = (idx_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (timer_q == T_FULL) begin
        timer_d = '0;
        push    = rx_s_q;
        bad     = !rx_s_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // FIFO bookkeeping: pops need data, pushes need room unless a pop frees it
  always_comb begin
    pop         = rd_en && !empty;
    wr          = push && (!full || pop);
    overrun_d   = push && full && !pop;
    frame_err_d = bad;
    wr_ptr_d    = wr_ptr_q + AW'(wr);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    count_d     = count_q + CW'(wr) - CW'(pop);
    mem_d       = mem_q;
    if (wr) mem_d[wr_ptr_q] = shift_q;
  end
  // Control state, synchronizer and pointers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      timer_q     <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end
  // Storage array; contents beyond count are never observed, so no reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed checks of framing, glitch rejection, FIFO limits and reset
module tb_uart_rx;
  localparam int CPB = 4;
  logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, rd_en = 1'b0;
  logic [7:0] dout;
  logic       empty, full, frame_err, overrun;
  int n_chk = 0, n_fail = 0, fe_cnt = 0, ov_cnt = 0, fe0 = 0, ov0 = 0;

  uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(3)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en), .dout(dout),
    .empty(empty), .full(full), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Count every cycle each error strobe is high
  always @(posedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive bit-cycles lo..hi-1 of a frame {stop, data, start}
  task automatic send(input logic [7:0] b, input logic stop, input int lo = 0, input int hi = 40);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      rx = f[i / CPB];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check({tag, "_nonempty"}, empty, 1'b0);
    check(tag, dout, exp);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_dout", dout, 8'h00);
    rst = 1'b0;
    // rd_en on an empty FIFO is ignored
    @(negedge clk) rd_en = 1'b1;
    @(negedge clk) rd_en = 1'b0;
    check("rd_empty_empty", empty, 1'b1);
    check("rd_empty_full", full, 1'b0);
    // 0x55 with a pop attempted in the push cycle while empty: push only
    fe0 = fe_cnt; ov0 = ov_cnt;
    send(8'h55, 1'b1);
    @(negedge clk) begin rx = 1'b1; rd_en = 1'b1; end
    @(negedge clk) rd_en = 1'b0;
    check("b55_empty", empty, 1'b0);
    check("b55_dout", dout, 8'h55);
    rd_en = 1'b1;
    @(negedge clk) rd_en = 1'b0;
    check("b55_popped", empty, 1'b1);
    check("b55_fe", fe_cnt - fe0, 0);
    check("b55_ov", ov_cnt - ov0, 0);
    idle(4);
    // one-cycle low glitch is rejected, then a real frame still works
    @(negedge clk) rx = 1'b0;
    @(negedge clk) rx = 1'b1;
    idle(8);
    check("glitch_empty", empty, 1'b1);
    check("glitch_fe", fe_cnt - fe0, 0);
    send(8'h5A, 1'b1);
    idle(3);
    pop_check("after_glitch", 8'h5A);
    check("after_glitch_empty", empty, 1'b1);
    // bad stop bit
    fe0 = fe_cnt;
    send(8'hA3, 1'b0);
    idle(8);
    check("ferr_pulse", fe_cnt - fe0, 1);
    check("ferr_empty", empty, 1'b1);
    // nine back-to-back frames into an 8-deep FIFO
    fe0 = fe_cnt; ov0 = ov_cnt;
    for (int i = 0; i < 8; i++) send(8'(i), 1'b1);
    send(8'h08, 1'b1, 0, 2);
    check("full_after_8", full, 1'b1);
    check("no_ov_at_8", ov_cnt - ov0, 0);
    send(8'h08, 1'b1, 2, 40);
    idle(3);
    check("full_after_9", full, 1'b1);
    check("ov_pulse", ov_cnt - ov0, 1);
    check("ov_no_fe", fe_cnt - fe0, 0);
    for (int i = 0; i < 8; i++) pop_check($sformatf("ovf_rd%0d", i), 8'(i));
    @(negedge clk);
    check("ovf_drained", empty, 1'b1);
    // push and pop together while full
    ov0 = ov_cnt;
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b1);
    send(8'h18, 1'b1);
    @(negedge clk);
    check("pp_full_before", full, 1'b1);
    check("pp_head", dout, 8'h10);
    rx = 1'b1;
    rd_en = 1'b1;
    @(negedge clk) rd_en = 1'b0;
    check("pp_full_after", full, 1'b1);
    idle(3);
    check("pp_no_ov", ov_cnt - ov0, 0);
    for (int i = 1; i < 9; i++) pop_check($sformatf("pp_rd%0d", i), 8'h10 + 8'(i));
    @(negedge clk);
    check("pp_drained", empty, 1'b1);
    // reset mid-frame abandons the partial byte
    fe0 = fe_cnt; ov0 = ov_cnt;
    idle(4);
    send(8'hFF, 1'b1, 0, 22);
    @(negedge clk) begin rst = 1'b1; rx = 1'b1; end
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    check("midrst_empty", empty, 1'b1);
    idle(4);
    send(8'h3C, 1'b1);
    idle(3);
    pop_check("midrst_rx", 8'h3C);
    check("midrst_only_one", empty, 1'b1);
    check("midrst_fe", fe_cnt - fe0, 0);
    check("midrst_ov", ov_cnt - ov0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
